mem_stage: RTL and testbench

- Memory-access pipeline stage. Sits directly downstream of the execute stage, behind the ex/mem pipeline register.
- Consumes the execute stage's write-back tuple (wd, wreg, wdata), its memory opcode (aluop) and its effective address.
- Runs byte-serial load/store transactions against the 8-bit memory controller, then hands the write-back tuple to the mem/wb register.
- Non-memory ops pass through combinationally. Memory ops stall the pipeline until the final byte completes.

---
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - byte-serial load/store memory stage between ex/mem and mem/wb
`ifndef MEM_STAGE_ALUOP_DEFS
`define MEM_STAGE_ALUOP_DEFS
`define AluOpBus 7:0
`define EX_LB    8'h20
`define EX_LH    8'h21
`define EX_LW    8'h22
`define EX_LBU   8'h23
`define EX_LHU   8'h24
`define EX_SB    8'h28
`define EX_SH    8'h29
`define EX_SW    8'h2A
`endif

module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [`AluOpBus]  aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_req_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_acc;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic [1:0]  w_last;
  logic        w_active;
  logic        w_req;
  logic        w_ack;
  logic [31:0] w_ext;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_last     = 2'd0;
    case (aluop_i)
      `EX_LB, `EX_LBU: begin w_is_load  = 1'b1; w_last = 2'd0; end
      `EX_LH, `EX_LHU: begin w_is_load  = 1'b1; w_last = 2'd1; end
      `EX_LW:          begin w_is_load  = 1'b1; w_last = 2'd3; end
      `EX_SB:          begin w_is_store = 1'b1; w_last = 2'd0; end
      `EX_SH:          begin w_is_store = 1'b1; w_last = 2'd1; end
      `EX_SW:          begin w_is_store = 1'b1; w_last = 2'd3; end
      default:         ;
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;
  assign w_active = ((r_state == S_IDLE) && w_is_mem) || (r_state == S_ACCESS);
  // Request is combinational from ex/mem in IDLE, so it must also be masked by reset.
  assign w_req    = w_active & rdy & rst;
  assign w_ack    = w_req & mem_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_acc   <= 32'd0;
    end else if (rdy) begin
      if (w_ack && w_is_load) r_acc[{r_cnt, 3'b000} +: 8] <= mem_rdata_i;
      case (r_state)
        S_IDLE, S_ACCESS: begin
          if (w_active) begin
            if (w_ack && (r_cnt == w_last)) begin
              r_state <= S_DONE;
              r_cnt   <= 2'd0;
            end else begin
              r_state <= S_ACCESS;
              if (w_ack) r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (aluop_i)
      `EX_LB:  w_ext = {{24{r_acc[7]}}, r_acc[7:0]};
      `EX_LH:  w_ext = {{16{r_acc[15]}}, r_acc[15:0]};
      `EX_LBU: w_ext = {24'd0, r_acc[7:0]};
      `EX_LHU: w_ext = {16'd0, r_acc[15:0]};
      default: w_ext = r_acc;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'd0;
    stall_req_o = 1'b0;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    if (rst) begin
      mem_req_o   = w_req;
      mem_we_o    = w_active & w_is_store;
      mem_addr_o  = mem_addr_i + ADDR_W'(r_cnt);
      mem_wdata_o = wdata_i[{r_cnt, 3'b000} +: 8];
      stall_req_o = w_active;
      if ((r_state == S_IDLE) && !w_is_mem) begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
      end else if ((r_state == S_DONE) && w_is_load) begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = w_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h22;
  localparam logic [7:0] OP_LBU = 8'h23;
  localparam logic [7:0] OP_LHU = 8'h24;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2A;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_req_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
  );

  typedef struct {
    logic [7:0]       op;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [4:0]       wd;
    logic             wreg;
    logic [3:0][7:0]  rd;
    int               n;
    logic             we;
    logic [4:0]       exp_wd;
    logic             exp_wreg;
    logic [31:0]      exp_wdata;
  } vec_t;

  vec_t tbl[10];
  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic go_idle();
    aluop_i = OP_NOP; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'd0;
    mem_ack_i = 1'b0; mem_rdata_i = 8'd0;
  endtask

  task automatic run_vec(input vec_t v);
    n_vec++;
    rdy = 1'b1;
    wd_i = v.wd; wreg_i = v.wreg; wdata_i = v.wdata; aluop_i = v.op; mem_addr_i = v.addr;
    if (v.n == 0) begin
      mem_ack_i = 1'b1;
      #3;
      chk("pass_wd", 32'(wd_o), 32'(v.exp_wd));
      chk("pass_wreg", 32'(wreg_o), 32'(v.exp_wreg));
      chk("pass_wdata", wdata_o, v.exp_wdata);
      chk("pass_stall", 32'(stall_req_o), 32'd0);
      chk("pass_req", 32'(mem_req_o), 32'd0);
      @(posedge clk); #1;
      go_idle();
      return;
    end
    for (int b = 0; b < v.n; b++) begin
      mem_ack_i = 1'b1; mem_rdata_i = v.rd[b];
      #3;
      chk("byte_req", 32'(mem_req_o), 32'd1);
      chk("byte_addr", mem_addr_o, v.addr + 32'(b));
      chk("byte_we", 32'(mem_we_o), 32'(v.we));
      chk("byte_stall", 32'(stall_req_o), 32'd1);
      chk("byte_wreg", 32'(wreg_o), 32'd0);
      if (v.we) chk("byte_wdata", 32'(mem_wdata_o), 32'(v.wdata[8*b +: 8]));
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0; mem_rdata_i = 8'd0;
    #3;
    chk("done_stall", 32'(stall_req_o), 32'd0);
    chk("done_req", 32'(mem_req_o), 32'd0);
    chk("done_wd", 32'(wd_o), 32'(v.exp_wd));
    chk("done_wreg", 32'(wreg_o), 32'(v.exp_wreg));
    chk("done_wdata", wdata_o, v.exp_wdata);
    @(posedge clk); #1;
    go_idle();
    #3;
    chk("after_req", 32'(mem_req_o), 32'd0);
    chk("after_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    //          op      addr          wdata          wd     wreg  rd bytes (b3..b0)             n  we    ewd    ewreg ewdata
    tbl[0] = '{OP_LW,  32'h0000_1000, 32'h0,         5'd3,  1'b1, {8'h12,8'h34,8'h56,8'h78}, 4, 1'b0, 5'd3,  1'b1, 32'h1234_5678};
    tbl[1] = '{OP_LB,  32'h0000_0020, 32'h0,         5'd4,  1'b1, {8'h00,8'h00,8'h00,8'h80}, 1, 1'b0, 5'd4,  1'b1, 32'hFFFF_FF80};
    tbl[2] = '{OP_LBU, 32'h0000_0020, 32'h0,         5'd4,  1'b1, {8'h00,8'h00,8'h00,8'h80}, 1, 1'b0, 5'd4,  1'b1, 32'h0000_0080};
    tbl[3] = '{OP_LH,  32'h0000_0020, 32'h0,         5'd6,  1'b1, {8'h00,8'h00,8'h92,8'h34}, 2, 1'b0, 5'd6,  1'b1, 32'hFFFF_9234};
    tbl[4] = '{OP_LHU, 32'h0000_0041, 32'h0,         5'd6,  1'b1, {8'h00,8'h00,8'h92,8'h34}, 2, 1'b0, 5'd6,  1'b1, 32'h0000_9234};
    tbl[5] = '{OP_SH,  32'h0000_2002, 32'h0000_BEEF, 5'd9,  1'b1, {8'h00,8'h00,8'h00,8'h00}, 2, 1'b1, 5'd0,  1'b0, 32'h0};
    tbl[6] = '{OP_SB,  32'h0000_3000, 32'h0000_00A5, 5'd7,  1'b1, {8'h00,8'h00,8'h00,8'h00}, 1, 1'b1, 5'd0,  1'b0, 32'h0};
    tbl[7] = '{OP_SW,  32'h0000_0010, 32'hDEAD_BEEF, 5'd2,  1'b0, {8'h00,8'h00,8'h00,8'h00}, 4, 1'b1, 5'd0,  1'b0, 32'h0};
    tbl[8] = '{OP_ADD, 32'h0000_0000, 32'h0000_0007, 5'd5,  1'b1, {8'h00,8'h00,8'h00,8'h00}, 0, 1'b0, 5'd5,  1'b1, 32'h0000_0007};
    tbl[9] = '{OP_LW,  32'h0000_0FFE, 32'h0,         5'd31, 1'b1, {8'h80,8'h00,8'hFF,8'h01}, 4, 1'b0, 5'd31, 1'b1, 32'h8000_FF01};

    // Reset state with a pass-through tuple and a memory op presented
    rst = 1'b0; rdy = 1'b1; go_idle(); mem_addr_i = 32'h1234;
    aluop_i = OP_ADD; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h7;
    #3;
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    aluop_i = OP_LW; mem_ack_i = 1'b1;
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; go_idle();
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // LW frozen by rdy=0 after the 2nd ack, with a spurious ack while frozen
    n_vec++;
    aluop_i = OP_LW; mem_addr_i = 32'h100; wd_i = 5'd8; wreg_i = 1'b1;
    mem_ack_i = 1'b1; mem_rdata_i = 8'h11;
    @(posedge clk); #1;
    mem_rdata_i = 8'h22;
    @(posedge clk); #1;
    rdy = 1'b0; mem_rdata_i = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("frz_req", 32'(mem_req_o), 32'd0);
      chk("frz_stall", 32'(stall_req_o), 32'd1);
      chk("frz_addr", mem_addr_o, 32'h102);
      @(posedge clk); #1;
    end
    rdy = 1'b1; mem_rdata_i = 8'h33;
    #3;
    chk("frz_resume_addr", mem_addr_o, 32'h102);
    @(posedge clk); #1;
    mem_rdata_i = 8'h44;
    #3;
    chk("frz_last_addr", mem_addr_o, 32'h103);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    #3;
    chk("frz_wdata", wdata_o, 32'h4433_2211);
    chk("frz_wreg", 32'(wreg_o), 32'd1);
    chk("frz_stall_done", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1;
    go_idle();
    @(posedge clk); #1;

    // Reset mid-SW after the first ack
    n_vec++;
    aluop_i = OP_SW; mem_addr_i = 32'h200; wdata_i = 32'hCAFE_F00D; wd_i = 5'd1; wreg_i = 1'b1;
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    #1;
    chk("sw_second_addr", mem_addr_o, 32'h201);
    rst = 1'b0;
    #1;
    chk("mrst_req", 32'(mem_req_o), 32'd0);
    chk("mrst_stall", 32'(stall_req_o), 32'd0);
    chk("mrst_we", 32'(mem_we_o), 32'd0);
    chk("mrst_addr", mem_addr_o, 32'd0);
    chk("mrst_mwdata", 32'(mem_wdata_o), 32'd0);
    chk("mrst_wreg", 32'(wreg_o), 32'd0);
    chk("mrst_wdata", wdata_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; go_idle();
    #3;
    chk("post_rst_stall", 32'(stall_req_o), 32'd0);
    chk("post_rst_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
